alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Decodes an incoming ALU operation class/funct3/funct7 into an ALU op code
//   and buffers {op, tag, illegal} in a 2-entry FIFO toward the ALU stage.
//   All outputs are driven from FIFO registers only (no input-to-output path).
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   flush               : synchronous clear of all buffered entries
//   in_valid/in_ready   : decode-side handshake
//   alu_op/funct3/funct7: operation class and instruction fields to decode
//   in_tag              : opaque destination tag, passed through unchanged
//   out_valid/out_ready : ALU-side handshake for the head entry
//   out_op/out_tag      : op code and tag of the head entry
//   out_illegal         : head entry came from an illegal encoding
//
// Configuration macro
//   ALU_ILLEGAL_TRAP_EN : when defined, the illegal flag is stored per entry
//                         and shown on out_illegal; otherwise out_illegal is 0.
module alu_issue_ctrl #(
    parameter int TAG_WIDTH     = 5,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               alu_op,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] out_op,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic                     out_illegal
);

    // ---------------- decode ----------------
    logic [3:0] w_dec_op;
    logic       w_dec_ill;
    logic       w_f7_zero;
    logic       w_f7_alt;
    logic       w_imm;      // I-type: funct7 is immediate bits, mostly ignored

    assign w_f7_zero = (funct7 == 7'b0000000);
    assign w_f7_alt  = (funct7 == 7'b0100000);
    assign w_imm     = (alu_op == 3'b011);

    always_comb begin
        w_dec_op  = 4'b0011;
        w_dec_ill = 1'b0;
        case (alu_op)
            3'b000: w_dec_op = 4'b0011;
            3'b001: begin
                case (funct3)
                    3'b000:  w_dec_op = 4'b1000;
                    3'b001:  w_dec_op = 4'b1001;
                    3'b100:  w_dec_op = 4'b1010;
                    3'b101:  w_dec_op = 4'b1011;
                    3'b110:  w_dec_op = 4'b1110;
                    3'b111:  w_dec_op = 4'b1111;
                    default: w_dec_ill = 1'b1;
                endcase
            end
            3'b010, 3'b011: begin
                case (funct3)
                    3'b000: begin
                        if (w_imm || w_f7_zero) w_dec_op = 4'b0011;
                        else if (w_f7_alt)      w_dec_op = 4'b0100;
                        else                    w_dec_ill = 1'b1;
                    end
                    // shift-left needs a clean funct7 in both classes
                    3'b001: begin
                        if (w_f7_zero) w_dec_op = 4'b0111;
                        else           w_dec_ill = 1'b1;
                    end
                    3'b101: begin
                        if (w_f7_zero)     w_dec_op = 4'b0101;
                        else if (w_f7_alt) w_dec_op = 4'b0110;
                        else               w_dec_ill = 1'b1;
                    end
                    default: begin
                        if (w_imm || w_f7_zero) begin
                            case (funct3)
                                3'b010:  w_dec_op = 4'b1010;
                                3'b011:  w_dec_op = 4'b1110;
                                3'b100:  w_dec_op = 4'b0010;
                                3'b110:  w_dec_op = 4'b0001;
                                default: w_dec_op = 4'b0000;
                            endcase
                        end else begin
                            w_dec_ill = 1'b1;
                        end
                    end
                endcase
            end
            3'b100:  w_dec_op = 4'b1101;
            3'b101:  w_dec_op = 4'b1100;
            default: w_dec_ill = 1'b1;
        endcase
    end

    // illegal encodings still flow down the pipe, carrying a harmless ADD
    logic [OPCODE_LENGTH-1:0] w_push_op;
    assign w_push_op = w_dec_ill ? OPCODE_LENGTH'(4'b0011) : OPCODE_LENGTH'(w_dec_op);

    // ---------------- 2-entry FIFO ----------------
    // Entry 0 is always the head; a pop shifts entry 1 down.
    logic [OPCODE_LENGTH-1:0] r_op  [2];
    logic [TAG_WIDTH-1:0]     r_tag [2];
    logic [1:0]               r_count;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_wr_idx;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    // slot that is free after this cycle's pop has been applied
    assign w_wr_idx  = (r_count == 2'd1) && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= 2'd0;
            r_op[0]  <= '0;
            r_op[1]  <= '0;
            r_tag[0] <= '0;
            r_tag[1] <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_op[0]  <= r_op[1];
                r_tag[0] <= r_tag[1];
            end
            if (w_push) begin
                r_op[w_wr_idx]  <= w_push_op;
                r_tag[w_wr_idx] <= in_tag;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_op  = r_op[0];
    assign out_tag = r_tag[0];

`ifdef ALU_ILLEGAL_TRAP_EN
    logic r_ill [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ill[0] <= 1'b0;
            r_ill[1] <= 1'b0;
        end else if (!flush) begin
            if (w_pop)  r_ill[0]        <= r_ill[1];
            if (w_push) r_ill[w_wr_idx] <= w_dec_ill;
        end
    end

    assign out_illegal = r_ill[0];
`else
    assign out_illegal = 1'b0;
`endif

endmodule
